bit_serial_adder: RTL and testbench

BIT_SERIAL_ADDER -- requirements
Module: bit_serial_adder

---
 rtl/bit_serial_adder.sv | 136 +++++++++++++
 tb/tb_bit_serial_adder.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/bit_serial_adder.sv
// ---------------------------------------------------------------------------
// bit_serial_adder
//   Adds two WIDTH-bit operands plus a carry-in, one bit per clock, LSB
//   first. A single shared full-add cell (two half adders and an OR) is used
//   for every bit position.
//
//   Ports
//     clk    in   1      rising-edge clock
//     rstn   in   1      synchronous active-low reset
//     start  in   1      request a new addition (sampled in IDLE only)
//     A, B   in   WIDTH  operands, captured when start is accepted
//     cin    in   1      carry-in, captured when start is accepted
//     busy   out  1      high while an operation occupies the unit (RUN, DONE)
//     done   out  1      one-cycle pulse: sum/carry hold a fresh result
//     sum    out  WIDTH  registered result
//     carry  out  1      registered carry-out of the MSB
// ---------------------------------------------------------------------------

// Half adder used twice to build the shared full-add cell.
module half_adder (
    input  logic a_i,
    input  logic b_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i;
    assign c_o = a_i & b_i;
endmodule

module bit_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sha_q, sha_d;     // operand A, shifted right each bit
    logic [WIDTH-1:0] shb_q, shb_d;     // operand B, shifted right each bit
    logic [WIDTH-1:0] res_q, res_d;     // partial result, filled from the MSB end
    logic [CW-1:0]    cnt_q, cnt_d;     // index of the bit processed this edge
    logic             cy_q,  cy_d;      // running carry
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;

    // Shared full-add cell.
    logic s1, c1, fa_s, c2, fa_c;

    half_adder u_ha0 (.a_i(sha_q[0]), .b_i(shb_q[0]), .s_o(s1),   .c_o(c1));
    half_adder u_ha1 (.a_i(s1),       .b_i(cy_q),     .s_o(fa_s), .c_o(c2));
    assign fa_c = c1 | c2;

    always_comb begin
        state_d = state_q;
        sha_d   = sha_q;
        shb_d   = shb_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        cy_d    = cy_q;
        sum_d   = sum_q;
        carry_d = carry_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    sha_d   = A;
                    shb_d   = B;
                    cy_d    = cin;
                    res_d   = '0;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                res_d = {fa_s, res_q[WIDTH-1:1]};
                sha_d = sha_q >> 1;
                shb_d = shb_q >> 1;
                cy_d  = fa_c;
                if (cnt_q == LAST) begin
                    // Only the final bit publishes; the counter is left at
                    // LAST rather than wrapping.
                    state_d = DONE;
                    sum_d   = {fa_s, res_q[WIDTH-1:1]};
                    carry_d = fa_c;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            sha_q   <= '0;
            shb_q   <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            cy_q    <= 1'b0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sha_q   <= sha_d;
            shb_q   <= shb_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            cy_q    <= cy_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

    assign busy  = (state_q != IDLE);
    assign done  = (state_q == DONE);
    assign sum   = sum_q;
    assign carry = carry_q;
endmodule

// File: tb/tb_bit_serial_adder.sv
module tb_bit_serial_adder;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rstn;
    logic         start;
    logic [W-1:0] A, B;
    logic         cin;
    logic         busy, done;
    logic [W-1:0] sum;
    logic         carry;

    int npass = 0;
    int ntotal = 0;

    bit_serial_adder #(.WIDTH(W)) dut (
        .clk(clk), .rstn(rstn), .start(start), .A(A), .B(B), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .carry(carry)
    );

    always #5 clk = ~clk;

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer addition.
    function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    endfunction

    // Launch one operation and observe it until the unit is idle again.
    // No comparisons here; callers check the returned observations.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          input int repulse, input bit tog,
                          output logic [W-1:0] s, output logic cy,
                          output int lat, output int bcnt, output int dcnt, output bit early);
        logic [W-1:0] s0;
        logic         c0;
        s0 = sum; c0 = carry;
        A = a; B = b; cin = c; start = 1'b1;
        tick();
        start = 1'b0;
        lat = -1; bcnt = 0; dcnt = 0; early = 1'b0;
        s = sum; cy = carry;
        for (int n = 0; n < 40; n++) begin
            if (!busy) break;
            bcnt++;
            if (done) begin
                dcnt++;
                if (lat < 0) begin lat = n; s = sum; cy = carry; end
            end else if (lat < 0 && (sum !== s0 || carry !== c0)) begin
                early = 1'b1;
            end
            if (tog) begin
                A = W'($urandom); B = W'($urandom); cin = 1'($urandom);
            end
            start = (n == repulse);
            if (start) begin A = 8'h01; B = 8'h01; cin = 1'b0; end
            tick();
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0; start = 1'b1; A = 8'hFF; B = 8'hFF; cin = 1'b1;
        tick(); tick();
        ntotal++;
        if ({busy, done, sum, carry} !== '0) $display("FAIL reset_outputs got busy=%b done=%b sum=%h carry=%b want all 0", busy, done, sum, carry);
        else npass++;
        start = 1'b0; rstn = 1'b1;
        tick(); tick();
        ntotal++;
        if (busy !== 1'b0) $display("FAIL reset_start_ignored got busy=%b want 0", busy);
        else npass++;
    endtask

    task automatic test_basic();
        logic [W-1:0] s; logic cy; int lat, bc, dc; bit early;
        run_op(8'hA5, 8'h5A, 1'b0, -1, 1'b0, s, cy, lat, bc, dc, early);
        ntotal++;
        if (lat !== 8) $display("FAIL basic_latency got %0d want 8", lat); else npass++;
        ntotal++;
        if ({cy, s} !== 9'h0FF) $display("FAIL basic_result got %b/%h want 0/ff", cy, s); else npass++;
        ntotal++;
        if (early) $display("FAIL basic_no_partial got early change want none"); else npass++;
        tick(); tick(); tick();
        ntotal++;
        if ({carry, sum} !== 9'h0FF) $display("FAIL basic_hold got %b/%h want 0/ff", carry, sum); else npass++;
    endtask

    task automatic test_carry();
        logic [W-1:0] s; logic cy; int lat, bc, dc; bit early;
        run_op(8'hFF, 8'h01, 1'b0, -1, 1'b0, s, cy, lat, bc, dc, early);
        ntotal++;
        if ({cy, s} !== 9'h100) $display("FAIL carry_ff_01 got %b/%h want 1/00", cy, s); else npass++;
        run_op(8'hFF, 8'hFF, 1'b1, -1, 1'b0, s, cy, lat, bc, dc, early);
        ntotal++;
        if ({cy, s} !== 9'h1FF) $display("FAIL carry_ff_ff_1 got %b/%h want 1/ff", cy, s); else npass++;
    endtask

    task automatic test_busy_reject();
        logic [W-1:0] s; logic cy; int lat, bc, dc; bit early;
        run_op(8'h10, 8'h20, 1'b0, 3, 1'b0, s, cy, lat, bc, dc, early);
        ntotal++;
        if (dc !== 1) $display("FAIL reject_done_count got %0d want 1", dc); else npass++;
        ntotal++;
        if (s !== 8'h30) $display("FAIL reject_sum got %h want 30", s); else npass++;
        ntotal++;
        if (bc !== 9) $display("FAIL reject_busy_cycles got %0d want 9", bc); else npass++;
        tick();
        ntotal++;
        if (busy !== 1'b0) $display("FAIL reject_not_queued got busy=%b want 0", busy); else npass++;
    endtask

    task automatic test_operand_change();
        logic [W-1:0] s; logic cy; int lat, bc, dc; bit early;
        run_op(8'h0F, 8'h01, 1'b0, -1, 1'b1, s, cy, lat, bc, dc, early);
        ntotal++;
        if ({cy, s} !== 9'h010) $display("FAIL operand_change got %b/%h want 0/10", cy, s); else npass++;
    endtask

    task automatic test_reset_mid_run();
        logic [W-1:0] s; logic cy; int lat, bc, dc; bit early;
        int seen;
        A = 8'hC3; B = 8'h7E; cin = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) seen++;
            tick();
        end
        ntotal++;
        if (seen !== 0) $display("FAIL midreset_no_done got %0d pulses want 0", seen); else npass++;
        ntotal++;
        if ({busy, carry, sum} !== '0) $display("FAIL midreset_state got busy=%b carry=%b sum=%h want 0/0/00", busy, carry, sum); else npass++;
        run_op(8'h03, 8'h04, 1'b0, -1, 1'b0, s, cy, lat, bc, dc, early);
        ntotal++;
        if ({cy, s} !== 9'h007) $display("FAIL midreset_next got %b/%h want 0/07", cy, s); else npass++;
    endtask

    // start held high: accepts at edges 0, 10, 20, ...; each done is seen
    // 8 edges after its accept and carries the operands of that edge.
    task automatic test_back_to_back();
        localparam int EDGES = 10000;
        logic [W-1:0] oa [EDGES];
        logic [W-1:0] ob [EDGES];
        logic         oc [EDGES];
        logic [W:0]   exp;
        int           bad_done, bad_res;
        bad_done = 0; bad_res = 0;
        start = 1'b1;
        for (int e = 0; e < EDGES; e++) begin
            A = W'($urandom); B = W'($urandom); cin = 1'($urandom);
            oa[e] = A; ob[e] = B; oc[e] = cin;
            tick();
            ntotal++;
            if (done !== (e % 10 == 8)) begin
                bad_done++;
                if (bad_done <= 5) $display("FAIL b2b_done_timing edge %0d got done=%b want %b", e, done, (e % 10 == 8));
            end else npass++;
            if (e % 10 == 8) begin
                exp = ref_add(oa[e-8], ob[e-8], oc[e-8]);
                ntotal++;
                if ({carry, sum} !== exp) begin
                    bad_res++;
                    if (bad_res <= 5) $display("FAIL b2b_result edge %0d got %b/%h want %b/%h", e, carry, sum, exp[W], exp[W-1:0]);
                end else npass++;
            end
        end
        start = 1'b0;
        tick(); tick(); tick();
    endtask

    initial begin
        rstn = 1'b1; start = 1'b0; A = '0; B = '0; cin = 1'b0;
        test_reset();
        test_basic();
        test_carry();
        test_busy_reject();
        test_operand_change();
        test_reset_mid_run();
        test_back_to_back();
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end
endmodule
